contador_param: RTL and testbench

CONTADOR_PARAM -- requirements
Module: contador_param

---
 rtl/contador_param.sv | 103 ++++++++++
 tb/tb_contador_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// Parameterised up/down/step counter with programmable terminal value,
// a registered wrap pulse and a combinational look-ahead carry for cascading.
module contador_param #(
    parameter int WIDTH = 16,
    parameter int STEP  = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enb_i,
    input  logic             cin_i,
    input  logic [1:0]       modo_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] q_o,
    output logic             rco_o,
    output logic             cout_o
);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_STEP = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] STEP_W = STEP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic [WIDTH-1:0] count_next;
    logic             wrap;
    logic             count_en;

    // Wrap condition and counting next value, both from the current Q only.
    always_comb begin
        wrap       = 1'b0;
        count_next = q_q;
        case (modo_i)
            MODO_UP: begin
                if (q_q >= limit_i) begin
                    wrap       = 1'b1;
                    count_next = '0;
                end else begin
                    count_next = q_q + ONE_W;
                end
            end
            MODO_DOWN: begin
                if (q_q > limit_i) begin
                    count_next = limit_i;
                end else if (q_q == '0) begin
                    wrap       = 1'b1;
                    count_next = limit_i;
                end else begin
                    count_next = q_q - ONE_W;
                end
            end
            MODO_STEP: begin
                // Out-of-range Q clamps to LIMIT without signalling a wrap.
                if (q_q > limit_i) begin
                    count_next = limit_i;
                end else if (q_q < STEP_W) begin
                    wrap       = 1'b1;
                    count_next = limit_i;
                end else begin
                    count_next = q_q - STEP_W;
                end
            end
            default: begin
                wrap       = 1'b0;
                count_next = q_q;
            end
        endcase
    end

    assign count_en = enb_i & cin_i & (modo_i != MODO_LOAD);

    always_comb begin
        q_d   = q_q;
        rco_d = 1'b0;
        if (enb_i) begin
            if (modo_i == MODO_LOAD) begin
                q_d = d_i;
            end else if (count_en) begin
                q_d   = count_next;
                rco_d = wrap;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q   <= '0;
            rco_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
        end
    end

    assign q_o    = q_q;
    assign rco_o  = rco_q;
    assign cout_o = count_en & wrap;

endmodule

// File: tb/tb_contador_param.sv
// Directed testbench for contador_param (WIDTH=4, STEP=3) including a
// two-stage cascade built from the carry look-ahead output.
module tb_contador_param;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enb, cin;
    logic [1:0]   modo;
    logic [W-1:0] d, limit;
    logic [W-1:0] q;
    logic         rco, cout;

    logic         c_modo_dummy;
    logic [W-1:0] q_lo, q_hi;
    logic         rco_lo, rco_hi, cout_lo, cout_hi;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(W), .STEP(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enb_i(enb), .cin_i(cin),
        .modo_i(modo), .d_i(d), .limit_i(limit),
        .q_o(q), .rco_o(rco), .cout_o(cout)
    );

    contador_param #(.WIDTH(W), .STEP(3)) u_lo (
        .clk_i(clk), .rst_n_i(rst_n), .enb_i(1'b1), .cin_i(1'b1),
        .modo_i(2'b00), .d_i(4'd0), .limit_i(4'd15),
        .q_o(q_lo), .rco_o(rco_lo), .cout_o(cout_lo)
    );

    contador_param #(.WIDTH(W), .STEP(3)) u_hi (
        .clk_i(clk), .rst_n_i(rst_n), .enb_i(1'b1), .cin_i(cout_lo),
        .modo_i(2'b00), .d_i(4'd0), .limit_i(4'd15),
        .q_o(q_hi), .rco_o(rco_hi), .cout_o(cout_hi)
    );

    assign c_modo_dummy = cout_hi;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] val);
        enb  = 1'b1;
        modo = 2'b11;
        d    = val;
        tick();
    endtask

    task automatic test_reset();
        enb = 1'b1; cin = 1'b1; modo = 2'b00; d = '0; limit = 4'd9;
        rst_n = 1'b0;
        #12;
        tests++;
        if (q !== 4'd0 || rco !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: q=%0d rco=%0b, required q=0 rco=0", q, rco);
        end
        tests++;
        if (cout !== 1'b0) begin
            fails++;
            $display("FAIL reset_cout: cout=%0b, required 0", cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_up_count();
        logic [W-1:0] exp_q;
        logic         exp_rco;
        exp_q = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            tests++;
            if (cout !== (exp_q == 4'd9)) begin
                fails++;
                $display("FAIL up_cout step %0d: cout=%0b q=%0d, required %0b", i, cout, q, exp_q == 4'd9);
            end
            tick();
            exp_rco = (exp_q == 4'd9);
            exp_q   = (exp_q == 4'd9) ? 4'd0 : exp_q + 4'd1;
            tests++;
            if (q !== exp_q || rco !== exp_rco) begin
                fails++;
                $display("FAIL up_count step %0d: q=%0d rco=%0b, required q=%0d rco=%0b", i, q, rco, exp_q, exp_rco);
            end
        end
    endtask

    task automatic test_down_step();
        logic [W-1:0] exp_q   [3] = '{4'd4, 4'd1, 4'd15};
        logic         exp_rco [3] = '{1'b0, 1'b0, 1'b1};
        logic         exp_cout[3] = '{1'b0, 1'b0, 1'b1};
        cin = 1'b1; limit = 4'd15;
        load(4'd7);
        tests++;
        if (q !== 4'd7) begin
            fails++;
            $display("FAIL step_load: q=%0d, required 7", q);
        end
        modo = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (cout !== exp_cout[i]) begin
                fails++;
                $display("FAIL step_cout %0d: cout=%0b, required %0b", i, cout, exp_cout[i]);
            end
            tick();
            tests++;
            if (q !== exp_q[i] || rco !== exp_rco[i]) begin
                fails++;
                $display("FAIL step_down %0d: q=%0d rco=%0b, required q=%0d rco=%0b", i, q, rco, exp_q[i], exp_rco[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        limit = 4'd5; cin = 1'b1;
        load(4'd12);
        tests++;
        if (q !== 4'd12) begin
            fails++;
            $display("FAIL oor_load: q=%0d, required 12", q);
        end
        modo = 2'b00;
        tick();
        tests++;
        if (q !== 4'd0 || rco !== 1'b1) begin
            fails++;
            $display("FAIL oor_up: q=%0d rco=%0b, required q=0 rco=1", q, rco);
        end
        load(4'd12);
        modo = 2'b01;
        tick();
        tests++;
        if (q !== 4'd5 || rco !== 1'b0) begin
            fails++;
            $display("FAIL oor_down: q=%0d rco=%0b, required q=5 rco=0", q, rco);
        end
        load(4'd13);
        modo = 2'b10;
        tick();
        tests++;
        if (q !== 4'd5 || rco !== 1'b0) begin
            fails++;
            $display("FAIL oor_step: q=%0d rco=%0b, required q=5 rco=0", q, rco);
        end
    endtask

    task automatic test_hold_gate();
        limit = 4'd9; cin = 1'b1;
        load(4'd3);
        modo = 2'b00; enb = 1'b0;
        tick();
        tests++;
        if (q !== 4'd3 || rco !== 1'b0) begin
            fails++;
            $display("FAIL hold_enb: q=%0d rco=%0b, required q=3 rco=0", q, rco);
        end
        enb = 1'b1; cin = 1'b0;
        #1;
        tests++;
        if (cout !== 1'b0) begin
            fails++;
            $display("FAIL hold_cout: cout=%0b, required 0", cout);
        end
        tick();
        tests++;
        if (q !== 4'd3 || rco !== 1'b0) begin
            fails++;
            $display("FAIL hold_cin: q=%0d rco=%0b, required q=3 rco=0", q, rco);
        end
        modo = 2'b11; d = 4'd9;
        tick();
        tests++;
        if (q !== 4'd9 || rco !== 1'b0) begin
            fails++;
            $display("FAIL load_cin0: q=%0d rco=%0b, required q=9 rco=0", q, rco);
        end
        cin = 1'b1;
    endtask

    task automatic test_limit_zero();
        logic [1:0] modes [3] = '{2'b00, 2'b01, 2'b10};
        limit = 4'd0;
        load(4'd0);
        for (int i = 0; i < 3; i++) begin
            modo = modes[i];
            #1;
            tests++;
            if (cout !== 1'b1) begin
                fails++;
                $display("FAIL lim0_cout mode %0d: cout=%0b, required 1", modes[i], cout);
            end
            tick();
            tests++;
            if (q !== 4'd0 || rco !== 1'b1) begin
                fails++;
                $display("FAIL lim0 mode %0d: q=%0d rco=%0b, required q=0 rco=1", modes[i], q, rco);
            end
        end
    endtask

    task automatic test_cascade();
        logic hi_rco_seen;
        hi_rco_seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tests++;
        if ({q_hi, q_lo} !== 8'd0) begin
            fails++;
            $display("FAIL cascade_reset: value=%0d, required 0", {q_hi, q_lo});
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rco_hi) hi_rco_seen = 1'b1;
            tests++;
            if ({q_hi, q_lo} !== 8'(i)) begin
                fails++;
                $display("FAIL cascade_count edge %0d: value=%0d, required %0d", i, {q_hi, q_lo}, i);
            end
        end
        tests++;
        if (hi_rco_seen !== 1'b0) begin
            fails++;
            $display("FAIL cascade_hi_rco: high rco asserted, required never");
        end
    endtask

    task automatic test_async_reset();
        cin = 1'b1; limit = 4'd6;
        load(4'd0);
        modo = 2'b01;
        tick();
        tests++;
        if (q !== 4'd6 || rco !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: q=%0d rco=%0b, required q=6 rco=1", q, rco);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (q !== 4'd0 || rco !== 1'b0) begin
            fails++;
            $display("FAIL areset_now: q=%0d rco=%0b, required q=0 rco=0", q, rco);
        end
        #1;
        rst_n = 1'b1;
        modo  = 2'b00;
        tick();
        tests++;
        if (q !== 4'd1 || rco !== 1'b0) begin
            fails++;
            $display("FAIL areset_resume: q=%0d rco=%0b, required q=1 rco=0", q, rco);
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_step();
        test_out_of_range();
        test_hold_gate();
        test_limit_zero();
        test_cascade();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
